// File: rtl/uart_stream_gen.sv
// Burst test-pattern source (counter / fixed byte / message buffer / LFSR) that drives
// a UART transmitter through its tx_start / tx_busy handshake.
module uart_stream_gen #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 4,
  parameter int GAP_W        = 16,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic              clk_25mhz,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [15:0]       burst_len,
  input  logic [GAP_W-1:0]  gap,
  input  logic [DATA_W-1:0] fixed_byte,
  input  logic [ADDR_W:0]   msg_len,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tx_busy,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  output logic              active,
  output logic              done,
  output logic [15:0]       byte_count,
  output logic              timeout_err
);
  localparam int MSG_DEPTH = 2 ** ADDR_W;
  localparam int TMR_W     = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [ADDR_W:0]  DEPTH_L  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_ACK, S_DRAIN, S_GAP} state_t;

  state_t state_reg, state_next;

  logic [DATA_W-1:0] msg_mem [MSG_DEPTH];

  logic [1:0]        mode_reg;
  logic [15:0]       burst_len_reg;
  logic [GAP_W-1:0]  gap_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic [DATA_W-1:0] fixed_reg;
  logic [ADDR_W:0]   msg_len_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [DATA_W-1:0] counter_reg;
  logic [15:0]       lfsr_reg;
  logic [TMR_W-1:0]  timer_reg;
  logic [DATA_W-1:0] tx_data_reg;
  logic [15:0]       byte_count_reg;
  logic              timeout_err_reg;
  logic              done_reg;

  logic              accept, load_fire, byte_done, timer_inc, timeout_set, gap_dec;
  logic [15:0]       count_inc;
  logic              last_byte;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W:0]   msg_len_clamp;
  logic [DATA_W-1:0] pattern;

  assign count_inc     = byte_count_reg + 16'd1;
  assign last_byte     = (burst_len_reg != 16'd0) && (count_inc == burst_len_reg);
  assign idx_inc       = {1'b0, idx_reg} + {{ADDR_W{1'b0}}, 1'b1};
  assign msg_len_clamp = (msg_len == '0 || msg_len > DEPTH_L) ? DEPTH_L : msg_len;

  always_comb begin
    pattern = counter_reg;
    case (mode_reg)
      2'd0: pattern = counter_reg;
      2'd1: pattern = fixed_reg;
      2'd2: pattern = msg_mem[idx_reg];
      default: pattern = lfsr_reg[DATA_W-1:0];
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (!resetn) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  // Abort overrides every transition, including a start offered in IDLE.
  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    load_fire   = 1'b0;
    byte_done   = 1'b0;
    timer_inc   = 1'b0;
    timeout_set = 1'b0;
    gap_dec     = 1'b0;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: if (start) begin
          accept     = 1'b1;
          state_next = S_LOAD;
        end
        S_LOAD: if (!tx_busy) begin
          load_fire  = 1'b1;
          state_next = S_START;
        end
        S_START: state_next = S_ACK;
        S_ACK: begin
          if (tx_busy) begin
            state_next = S_DRAIN;
          end else if (timer_reg == TMR_LAST) begin
            timeout_set = 1'b1;
            byte_done   = 1'b1;
          end else begin
            timer_inc = 1'b1;
          end
        end
        S_DRAIN: if (!tx_busy) byte_done = 1'b1;
        S_GAP: begin
          if (gap_cnt_reg <= GAP_W'(1)) state_next = S_LOAD;
          else                          gap_dec    = 1'b1;
        end
        default: state_next = S_IDLE;
      endcase
      if (byte_done) begin
        if (last_byte)             state_next = S_IDLE;
        else if (gap_reg == '0)    state_next = S_LOAD;
        else                       state_next = S_GAP;
      end
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (wr_en) msg_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk_25mhz) begin
    if (!resetn) begin
      mode_reg        <= '0;
      burst_len_reg   <= '0;
      gap_reg         <= '0;
      gap_cnt_reg     <= '0;
      fixed_reg       <= '0;
      msg_len_reg     <= DEPTH_L;
      idx_reg         <= '0;
      counter_reg     <= '0;
      lfsr_reg        <= 16'hACE1;
      timer_reg       <= '0;
      tx_data_reg     <= '0;
      byte_count_reg  <= '0;
      timeout_err_reg <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      if (accept) begin
        mode_reg        <= mode;
        burst_len_reg   <= burst_len;
        gap_reg         <= gap;
        fixed_reg       <= fixed_byte;
        msg_len_reg     <= msg_len_clamp;
        byte_count_reg  <= '0;
        counter_reg     <= '0;
        idx_reg         <= '0;
        timeout_err_reg <= 1'b0;
        lfsr_reg        <= 16'hACE1;
      end
      if (load_fire) tx_data_reg <= pattern;
      if (state_reg == S_START) timer_reg <= '0;
      else if (timer_inc)       timer_reg <= timer_reg + TMR_W'(1);
      if (timeout_set) timeout_err_reg <= 1'b1;
      if (byte_done) begin
        byte_count_reg <= count_inc;
        counter_reg    <= counter_reg + DATA_W'(1);
        idx_reg        <= (idx_inc == msg_len_reg) ? '0 : idx_inc[ADDR_W-1:0];
        lfsr_reg       <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        gap_cnt_reg    <= gap_reg;
      end else if (gap_dec) begin
        gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
      end
      done_reg <= byte_done && last_byte;
    end
  end

  // tx_start is combinational so an abort in the START cycle can still suppress it.
  assign tx_start    = (state_reg == S_START) && !abort;
  assign tx_data     = tx_data_reg;
  assign active      = (state_reg != S_IDLE);
  assign done        = done_reg;
  assign byte_count  = byte_count_reg;
  assign timeout_err = timeout_err_reg;
endmodule

// File: doc/uart_stream_gen.md
# uart_stream_gen

Parametrised UART test-pattern source feeding the UART transmitter's byte/start/busy handshake. Streams bursts of bytes in one of four modes: incrementing counter, fixed byte, a message buffer writable at runtime, or an LFSR sequence. Per-burst settings are length, inter-byte gap and message length. Sits between board-level control (buttons/host) and the UART TX block on the 25 MHz domain.

## Interface
- DATA_W, 8: byte width; 1..16.
- ADDR_W, 4: message buffer address width; depth MSG_DEPTH = 2**ADDR_W.
- GAP_W, 16: width of the gap setting.
- BUSY_TIMEOUT, 255: max cycles waiting for tx_busy to rise after tx_start.

- clk_25mhz  in  1  system clock.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to begin a burst; ignored while active.
- abort  in  1  terminate the burst; has priority over everything.
- mode  in  2  0 counter, 1 fixed byte, 2 message buffer, 3 LFSR.
- burst_len  in  16  bytes per burst; 0 = continuous until abort.
- gap  in  GAP_W  idle cycles inserted between bytes.
- fixed_byte  in  DATA_W  byte sent in mode 1.
- msg_len  in  ADDR_W+1  message length; 0 or >MSG_DEPTH means MSG_DEPTH.
- wr_en, wr_addr[ADDR_W], wr_data[DATA_W]  in  buffer write port, usable at any time.
- tx_busy  in  1  UART TX busy.
- tx_data  out  DATA_W  byte to send.
- tx_start  out  1  one-cycle send strobe.
- active  out  1  high from LOAD entry until return to IDLE.
- done  out  1  one-cycle pulse on normal burst completion.
- byte_count  out  16  bytes completed in the current or last burst.
- timeout_err  out  1  sticky; cleared on the next accepted start.

## Operation
- Reset values: tx_data 0, tx_start 0, active 0, done 0, byte_count 0, timeout_err 0, FSM in IDLE. Buffer contents are not reset.
- IDLE: on start with abort low:
  - latch mode, burst_len, gap, fixed_byte and clamped msg_len;
  - clear byte_count, counter, msg index and timeout_err;
  - set LFSR to 16'hACE1;
  - go to LOAD.
- LOAD: wait while tx_busy=1. Otherwise register tx_data from the pattern and go to START.
  - mode 0: counter value.
  - mode 1: latched fixed_byte.
  - mode 2: buf[index].
  - mode 3: lfsr[DATA_W-1:0].
- START: tx_start=1 for exactly this cycle, clear the timeout timer, go to ACK.
- ACK: if tx_busy=1, go to DRAIN. Otherwise increment the timer; when it reaches BUSY_TIMEOUT, set timeout_err and treat the byte as complete.
- DRAIN: wait for tx_busy=0, then the byte is complete.
- Byte complete:
  - byte_count+1;
  - counter+1 mod 2^DATA_W;
  - index+1, wrapping to 0 at msg_len;
  - LFSR steps once (next = {s[14:0], s15^s13^s12^s10}).
  - If burst_len≠0 and the new byte_count==burst_len: go to IDLE with done=1 for one cycle and no trailing gap.
  - Otherwise go to GAP with counter = latched gap.
- GAP: count down to 0, then go to LOAD. gap=0 goes straight to LOAD.
- Continuous mode: byte_count wraps FFFF→0000 with no other effect.
- abort in any state: go to IDLE next cycle. tx_start is forced 0 that cycle, done is not pulsed, and byte_count holds. A UART frame already in flight is not interrupted.
- start and abort in the same cycle: abort wins.
- Buffer writes land at the clock edge. A write to the address read in the same LOAD cycle returns the old data.

## Timing
- start sampled at cycle 0 with tx_busy=0: LOAD at cycle 1, tx_start at cycle 2.
- tx_data is valid from the tx_start cycle and held until the next LOAD exit.
- Minimum per-byte overhead beyond the UART busy time: 1 (DRAIN exit) + gap + 1 (LOAD) + 1 (START) + ACK cycles.
- done is asserted the cycle after tx_busy falls for the final byte.
- Settings inputs are ignored mid-burst; only the values latched at start apply.

## Test plan
- Mode 0, burst_len 4, gap 2, TX model busy 10 cycles from tx_start+1 -> bytes 00,01,02,03; successive tx_start pulses exactly 15 cycles apart; done pulses once; byte_count=4; active falls with done.
- Mode 2: write 48,45,4C,4C,4F to addr 0..4, msg_len 5, burst_len 7 -> H,E,L,L,O,H,E sent; index wraps after O.
- Mode 3, DATA_W 8, burst_len 3 -> E1, C3, 87.
- tx_busy held 0, BUSY_TIMEOUT 255, burst_len 2 -> each byte completes after 255 ACK cycles; timeout_err=1 and stays set; next start clears it.
- burst_len 0, mode 0, run 300 bytes, then abort during DRAIN -> counter wraps FF→00 at byte 257; IDLE the next cycle; no done; byte_count=300.
- start in the same cycle as abort, and start while active -> both ignored; no tx_start; settings unchanged.
